// File: rtl/fp_pkg.sv
// Shared constants and enums for the binary64 -> int64 converter.
package fp_pkg;

  localparam int FP_DATA_W = 64;
  localparam int FP_EXP_W  = 11;
  localparam int FP_MANT_W = 52;

  localparam logic signed [FP_EXP_W:0]   FP_BIAS        = 12'sd1023;
  localparam logic        [FP_EXP_W-1:0] FP_EXP_SPECIAL = '1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand classifier: sign, class, unbiased exponent, mantissa with hidden bit.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_W,
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int MANT_WIDTH = FP_MANT_W
) (
  input  logic [DATA_WIDTH-1:0]      num,
  output logic                       sign,
  output fp_class_t                  cls,
  output logic signed [EXP_WIDTH:0]  exp_unb,
  output logic [MANT_WIDTH:0]        mant_full
);

  logic [EXP_WIDTH-1:0]  exp_field;
  logic [MANT_WIDTH-1:0] mant;

  assign sign      = num[DATA_WIDTH-1];
  assign exp_field = num[DATA_WIDTH-2 -: EXP_WIDTH];
  assign mant      = num[MANT_WIDTH-1:0];
  assign exp_unb   = $signed({1'b0, exp_field}) - FP_BIAS;

  always_comb begin
    cls       = FP_NORM;
    mant_full = {1'b1, mant};
    if (exp_field == '0) begin
      mant_full = {1'b0, mant};
      cls       = (mant == '0) ? FP_ZERO : FP_SUB;
    end else if (exp_field == FP_EXP_SPECIAL) begin
      cls = (mant == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// Multi-cycle binary64 -> int64/uint64 converter, truncating toward zero, 1-bit/cycle shifter.
// Define FP_TO_INT_SATURATE_EN to return saturated values on overflow/invalid instead of 0.
module fp_to_int
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_W,
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int MANT_WIDTH = FP_MANT_W
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_num,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_flag_OF,
  output logic                  out_flag_NV,
  output logic                  out_flag_NX
);

  localparam int CNT_W = $clog2(MANT_WIDTH + 1);

  localparam logic signed [EXP_WIDTH:0] E_MANT = (EXP_WIDTH+1)'(MANT_WIDTH);
  localparam logic signed [EXP_WIDTH:0] E_SMAX = (EXP_WIDTH+1)'(DATA_WIDTH - 1);
  localparam logic signed [EXP_WIDTH:0] E_UMAX = (EXP_WIDTH+1)'(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nx;

  logic                      op_sign;
  fp_class_t                 op_cls;
  logic signed [EXP_WIDTH:0] op_exp;
  logic [MANT_WIDTH:0]       op_mant;

  logic                  accept;
  logic                  direct;
  logic                  shl;
  logic [CNT_W-1:0]      shamt;
  logic                  exact_min;
  logic                  ovf_norm;
  logic [DATA_WIDTH-1:0] sat_pos;
  logic [DATA_WIDTH-1:0] sat_neg;
  logic [DATA_WIDTH-1:0] d_result;
  logic                  d_of;
  logic                  d_nv;
  logic                  d_nx;

  logic [DATA_WIDTH-1:0] work;
  logic [CNT_W-1:0]      count;
  logic                  left;
  logic                  neg;
  logic [DATA_WIDTH-1:0] result;
  logic                  of_q;
  logic                  nv_q;
  logic                  nx_q;

  fp_unpack #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_unpack (
    .num       (in_num),
    .sign      (op_sign),
    .cls       (op_cls),
    .exp_unb   (op_exp),
    .mant_full (op_mant)
  );

  assign accept = (state == IDLE) && in_valid;

  // Classify the offered operand: either resolved immediately or handed to the shifter.
  always_comb begin
    direct    = 1'b1;
    d_result  = '0;
    d_of      = 1'b0;
    d_nv      = 1'b0;
    d_nx      = 1'b0;
    shl       = (op_exp >= E_MANT);
    shamt     = CNT_W'(shl ? (op_exp - E_MANT) : (E_MANT - op_exp));
    exact_min = in_signed && op_sign && (op_mant[MANT_WIDTH-1:0] == '0);
    ovf_norm  = in_signed ? ((op_exp > E_SMAX) || ((op_exp == E_SMAX) && !exact_min))
                          : (op_exp >= E_UMAX);
`ifdef FP_TO_INT_SATURATE_EN
    sat_pos   = in_signed ? S_MAX : '1;
    sat_neg   = in_signed ? S_MIN : '0;
`else
    sat_pos   = '0;
    sat_neg   = '0;
`endif
    if (op_cls == FP_NAN) begin
      d_nv     = 1'b1;
      d_result = sat_pos;
    end else if ((op_cls == FP_INF) || ((op_cls == FP_NORM) && ovf_norm)) begin
      d_of     = 1'b1;
      d_result = op_sign ? sat_neg : sat_pos;
    end else if (op_cls == FP_ZERO) begin
      d_result = '0;
    end else if (op_cls == FP_SUB) begin
      d_nx = 1'b1;
    end else if (op_exp[EXP_WIDTH]) begin
      d_nx = 1'b1;
    end else if (!in_signed && op_sign) begin
      d_nv     = 1'b1;
      d_result = sat_neg;
    end else begin
      direct = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    out_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        out_ready = 1'b1;
        if (in_valid) state_nx = direct ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (in_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // result only changes on entry to DONE, so it stays visible until the next result.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      work   <= '0;
      count  <= '0;
      left   <= 1'b0;
      neg    <= 1'b0;
      result <= '0;
      of_q   <= 1'b0;
      nv_q   <= 1'b0;
      nx_q   <= 1'b0;
    end else if (accept) begin
      of_q  <= d_of;
      nv_q  <= d_nv;
      nx_q  <= d_nx;
      work  <= {{(DATA_WIDTH-MANT_WIDTH-1){1'b0}}, op_mant};
      count <= shamt;
      left  <= shl;
      neg   <= in_signed && op_sign;
      if (direct) result <= d_result;
    end else if (state == SHIFT) begin
      if (count != '0) begin
        work  <= left ? {work[DATA_WIDTH-2:0], 1'b0} : {1'b0, work[DATA_WIDTH-1:1]};
        count <= count - CNT_W'(1);
        if (!left && work[0]) nx_q <= 1'b1;
      end else begin
        result <= neg ? -work : work;
      end
    end
  end

  assign out_result  = result;
  assign out_flag_OF = of_q;
  assign out_flag_NV = nv_q;
  assign out_flag_NX = nx_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: driver pushes expected results, negedge monitor checks them.
module tb_fp_to_int;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready;
  logic [63:0] in_num = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b1;
  logic [63:0] out_result;
  logic        out_flag_OF;
  logic        out_flag_NV;
  logic        out_flag_NX;

`ifdef FP_TO_INT_SATURATE_EN
  localparam logic [63:0] SAT_SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_SMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SAT_UMAX = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] SAT_SMAX = 64'h0;
  localparam logic [63:0] SAT_SMIN = 64'h0;
  localparam logic [63:0] SAT_UMAX = 64'h0;
`endif

  typedef struct {
    logic [63:0] num;
    logic        sgn;
    logic [63:0] res;
    logic        of_f;
    logic        nv_f;
    logic        nx_f;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur;
  bit   holding = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fp_to_int #(
    .DATA_WIDTH (64),
    .EXP_WIDTH  (11),
    .MANT_WIDTH (52)
  ) dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .in_num      (in_num),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .in_ready    (in_ready),
    .out_result  (out_result),
    .out_flag_OF (out_flag_OF),
    .out_flag_NV (out_flag_NV),
    .out_flag_NX (out_flag_NX)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic add(logic [63:0] num, logic sgn, logic [63:0] res,
                     logic of_f, logic nv_f, logic nx_f, int lat, int hold);
    vec_t v;
    v.num = num; v.sgn = sgn; v.res = res;
    v.of_f = of_f; v.nv_f = nv_f; v.nx_f = nx_f;
    v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge in_clk);
    while (!out_ready && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    if (!out_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got out_ready=0 required 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge in_clk);
    while (!out_valid && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got out_valid=0 required 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    wait_ready();
    #1;
    in_num    = v.num;
    in_signed = v.sgn;
    in_valid  = 1'b1;
    in_ready  = (v.hold == 0);
    @(posedge in_clk);
    #1;
    e.v   = v;
    e.acc = cyc;
    sb.push_back(e);
    in_valid  = 1'b0;
    in_num    = ~v.num;
    in_signed = ~v.sgn;
    if (v.hold > 0) begin
      wait_valid();
      repeat (v.hold) @(negedge in_clk);
      #1;
      in_ready = 1'b1;
    end
  endtask

  // Monitor: first cycle of out_valid checks value and latency, later cycles check stability.
  always @(negedge in_clk) begin
    if (!in_rst_n || !out_valid) begin
      holding = 1'b0;
    end else begin
      if (!holding) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got out_valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          holding = 1'b1;
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.v.lat));
        end
      end
      if (holding) begin
        chk("result", out_result, cur.v.res);
        chk("flag_OF", 64'(out_flag_OF), 64'(cur.v.of_f));
        chk("flag_NV", 64'(out_flag_NV), 64'(cur.v.nv_f));
        chk("flag_NX", 64'(out_flag_NX), 64'(cur.v.nx_f));
        chk("ready_in_done", 64'(out_ready), 64'(0));
      end
    end
  end

  initial begin
    //       num                    sgn result                 OF   NV   NX   lat hold
    add(64'h3FF0_0000_0000_0000, 1, 64'h1,                  0, 0, 0, 54, 0);
    add(64'hC004_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 53, 5);
    add(64'h43D0_0000_0000_0000, 1, 64'h4000_0000_0000_0000, 0, 0, 0, 12, 0);
    add(64'h43E0_0000_0000_0000, 1, SAT_SMAX,               1, 0, 0,  1, 0);
    add(64'h43E0_0000_0000_0000, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 13, 0);
    add(64'h7FF8_0000_0000_0000, 1, SAT_SMAX,               0, 1, 0,  1, 0);
    add(64'h7FF8_0000_0000_0000, 0, SAT_UMAX,               0, 1, 0,  1, 0);
    add(64'hBFF0_0000_0000_0000, 0, 64'h0,                  0, 1, 0,  1, 0);
    add(64'hC3E0_0000_0000_0000, 1, 64'h8000_0000_0000_0000, 0, 0, 0, 13, 0);
    add(64'hC3E0_0000_0000_0001, 1, SAT_SMIN,               1, 0, 0,  1, 0);
    add(64'h0000_0000_0000_0001, 1, 64'h0,                  0, 0, 1,  1, 0);
    add(64'h8000_0000_0000_0000, 0, 64'h0,                  0, 0, 0,  1, 0);
    add(64'h3FE0_0000_0000_0000, 1, 64'h0,                  0, 0, 1,  1, 0);
    add(64'hFFF0_0000_0000_0000, 1, SAT_SMIN,               1, 0, 0,  1, 0);
    add(64'h7FF0_0000_0000_0000, 0, SAT_UMAX,               1, 0, 0,  1, 0);
    add(64'h43F0_0000_0000_0000, 0, SAT_UMAX,               1, 0, 0,  1, 0);
    add(64'h43EF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_F800, 0, 0, 0, 13, 0);
    add(64'h4340_0000_0000_0000, 1, 64'h0020_0000_0000_0000, 0, 0, 0,  3, 0);
    add(64'h4330_0000_0000_0001, 1, 64'h0010_0000_0000_0001, 0, 0, 0,  2, 0);
    add(64'h3FF8_0000_0000_0000, 0, 64'h1,                  0, 0, 1, 54, 0);
    add(64'hC08F_4000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FC18, 0, 0, 0, 45, 0);

    repeat (3) @(posedge in_clk);
    #1;
    chk("reset_ready", 64'(out_ready), 64'(1));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_result", out_result, 64'h0);
    chk("reset_flags", {61'h0, out_flag_OF, out_flag_NV, out_flag_NX}, 64'h0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    foreach (vecs[i]) drive(vecs[i]);

    // Abort a conversion mid-shift; the previous nonzero result must be cleared too.
    wait_ready();
    #1;
    in_num    = 64'h3FF0_0000_0000_0000;
    in_signed = 1'b1;
    in_valid  = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge in_clk);
    #3;
    in_rst_n = 1'b0;
    #1;
    chk("midshift_ready", 64'(out_ready), 64'(1));
    chk("midshift_valid", 64'(out_valid), 64'(0));
    chk("midshift_result", out_result, 64'h0);
    chk("midshift_flags", {61'h0, out_flag_OF, out_flag_NV, out_flag_NX}, 64'h0);
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;

    drive(vecs[0]);
    drive(vecs[1]);
    wait_ready();
    repeat (2) @(negedge in_clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning FP operand and integer result width.
REQ-002 SHALL have parameter EXP_WIDTH, default 11, meaning exponent field width.
REQ-003 SHALL have parameter MANT_WIDTH, default 52, meaning stored mantissa width, hidden bit excluded.
REQ-004 SHALL have port in_clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port in_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning an operand is offered.
REQ-007 SHALL have port out_ready, output, 1, meaning the block accepts an operand.
REQ-008 SHALL have port in_num, input, DATA_WIDTH, the IEEE-754 binary64 operand.
REQ-009 SHALL have port in_signed, input, 1, selecting a signed (1) or unsigned (0) int64 target; sampled with in_num.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is held.
REQ-011 SHALL have port in_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port out_result, output, DATA_WIDTH, the integer result.
REQ-013 SHALL have ports out_flag_OF, out_flag_NV and out_flag_NX, outputs, 1 bit each, meaning overflow, invalid and inexact.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE; out_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 IDLE with in_valid=1 SHALL accept: latch sign, biased exponent E, mantissa {1,mant} (or {0,mant} if E==0), in_signed; e=E-1023.
REQ-016 Accept SHALL route directly to DONE at T+1 for: zero or subnormal (result 0, NX if mant!=0); e<0 (result 0, NX=1); NaN (NV=1); ±Inf or e>=63 signed / e>=64 unsigned (OF=1); unsigned with negative nonzero input (NV=1).
REQ-017 All other accepted operands SHALL enter SHIFT with count s=|e-52|; direction is left if e>=52, else right.
REQ-018 SHIFT SHALL shift the 64-bit working register 1 bit per cycle and decrement count; at count==0 it SHALL go to DONE; out_valid therefore first rises at T+s+2.
REQ-019 Any 1 bit shifted out on a right shift SHALL set NX sticky for the operation.
REQ-020 On entry to DONE for a signed target with sign=1, the result SHALL be the two's complement of the magnitude.
REQ-021 Signed e==63 SHALL be exact only for magnitude 2^63 with sign=1 (result 0x8000000000000000); otherwise OF=1.
REQ-022 DONE SHALL hold out_result and the flags stable until in_ready=1, then return to IDLE; no new operand SHALL be accepted in that cycle.
REQ-023 Flags SHALL be cleared at each accept.

Reset
REQ-024 in_rst_n=0 SHALL immediately force IDLE, out_result=0, all flags=0, out_valid=0, out_ready=1, including mid-SHIFT; the in-flight operand SHALL be discarded.

Configuration
REQ-025 With FP_TO_INT_SATURATE_EN defined, OF/NV cases SHALL return 0x7FFFFFFFFFFFFFFF or 0x8000000000000000 (signed, by sign; NaN->max) or 0xFFFFFFFFFFFFFFFF / 0 (unsigned, by sign; NaN->max).
REQ-026 Without FP_TO_INT_SATURATE_EN, OF/NV cases SHALL return 0; flags SHALL be identical in both builds.

Structure
REQ-027 Shared package fp_pkg SHALL hold the width constants, exponent bias 1023, the NaN/Inf exponent value and the FSM state enum.
REQ-028 Operand classification (zero/subnormal/normal/Inf/NaN, unbiased exponent) SHALL be a combinational sub-module named fp_unpack.

Verification
REQ-029 in_num=0x3FF0000000000000, signed -> out_result=1, NX=0, out_valid at T+54.
REQ-030 in_num=0xC004000000000000 (-2.5), signed -> out_result=0xFFFFFFFFFFFFFFFE, NX=1.
REQ-031 in_num=0x43D0000000000000 (2^62) -> out_result=0x4000000000000000 at T+12; 0x43E0000000000000 signed -> OF=1, result 0x7FFFFFFFFFFFFFFF (saturate) or 0; unsigned -> 0x8000000000000000, OF=0.
REQ-032 in_num=0x7FF8000000000000 -> NV=1 at T+1; 0xBFF0000000000000 unsigned -> NV=1, result 0.
REQ-033 in_ready=0 held 5 cycles in DONE -> out_result and flags stable, out_ready=0; in_rst_n pulsed low mid-SHIFT -> IDLE, outputs 0, next operand converts correctly.
